// File: rtl/ms_timer.sv
// Millisecond countdown timer: arms on start, counts time_ms ticks of TICK_DIV clocks,
// then raises a level done flag and a one-cycle irq. All outputs are registered.
module ms_timer #(
  parameter int CLK_FREQ_HZ = 27_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_ms,
  input  logic        start,
  input  logic        interrupt_enable,
  output logic        done,
  output logic        irq,
  output logic [15:0] remaining_ms
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic [15:0]     remaining_r, remaining_s;
  logic            done_r, done_s;
  logic            irq_r, irq_s;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      presc_r     <= '0;
      remaining_r <= 16'd0;
      done_r      <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      presc_r     <= presc_s;
      remaining_r <= remaining_s;
      done_r      <= done_s;
      irq_r       <= irq_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    presc_s     = presc_r;
    remaining_s = remaining_r;
    done_s      = done_r;
    irq_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (time_ms != 16'd0) begin
            state_s     = ST_RUN;
            remaining_s = time_ms;
            presc_s     = '0;
            done_s      = 1'b0;
          end else begin
            state_s     = ST_DONE;
            remaining_s = 16'd0;
            done_s      = 1'b1;
            irq_s       = interrupt_enable;
          end
        end else begin
          remaining_s = 16'd0;
          presc_s     = '0;
          done_s      = 1'b0;
        end
      end
      ST_RUN: begin
        // Abort takes priority over a final tick on the same edge
        if (!start) begin
          state_s     = ST_IDLE;
          remaining_s = 16'd0;
          presc_s     = '0;
          done_s      = 1'b0;
        end else if (presc_r == TICK_LAST) begin
          presc_s = '0;
          if (remaining_r <= 16'd1) begin
            state_s     = ST_DONE;
            remaining_s = 16'd0;
            done_s      = 1'b1;
            irq_s       = interrupt_enable;
          end else begin
            remaining_s = remaining_r - 16'd1;
          end
        end else begin
          presc_s = presc_r + PRESC_ONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_s = ST_IDLE;
          done_s  = 1'b0;
        end else begin
          done_s  = 1'b1;
        end
        remaining_s = 16'd0;
      end
      default: begin
        state_s     = ST_IDLE;
        presc_s     = '0;
        remaining_s = 16'd0;
        done_s      = 1'b0;
      end
    endcase
  end

  assign done         = done_r;
  assign irq          = irq_r;
  assign remaining_ms = remaining_r;

endmodule

// File: tb/tb_ms_timer.sv
// Directed bench for ms_timer: a TICK_DIV=4 instance for the functional cases and a
// TICK_DIV=1 instance for the full 16-bit countdown.
module tb_ms_timer;

  logic        clk;
  logic        rst;
  logic [15:0] time_ms;
  logic        start;
  logic        interrupt_enable;
  logic        done;
  logic        irq;
  logic [15:0] remaining_ms;

  logic [15:0] b_time_ms;
  logic        b_start;
  logic        b_interrupt_enable;
  logic        b_done;
  logic        b_irq;
  logic [15:0] b_remaining_ms;

  int checks;
  int failures;
  int b_irq_count;

  ms_timer #(.CLK_FREQ_HZ(4000)) dut (
    .clk(clk), .rst(rst), .time_ms(time_ms), .start(start),
    .interrupt_enable(interrupt_enable), .done(done), .irq(irq),
    .remaining_ms(remaining_ms)
  );

  ms_timer #(.CLK_FREQ_HZ(1000)) dut_fast (
    .clk(clk), .rst(rst), .time_ms(b_time_ms), .start(b_start),
    .interrupt_enable(b_interrupt_enable), .done(b_done), .irq(b_irq),
    .remaining_ms(b_remaining_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Arms from IDLE at the current negedge and checks every cycle until one past expiry.
  task automatic run_and_check(input logic [15:0] tm, input logic ie, input logic change_mid);
    int last;
    last = int'(tm) * 4;
    time_ms = tm;
    interrupt_enable = ie;
    start = 1'b1;
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      if (change_mid && k == 2) time_ms = 16'd9;
      check("run_done", 32'(done), 32'(k >= last));
      check("run_irq", 32'(irq), 32'(ie && (k == last)));
      check("run_rem", 32'(remaining_ms), (k >= last) ? 32'd0 : 32'(int'(tm) - k / 4));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    b_irq_count = 0;
    rst = 1'b1;
    time_ms = 16'd0;
    start = 1'b0;
    interrupt_enable = 1'b0;
    b_time_ms = 16'd0;
    b_start = 1'b0;
    b_interrupt_enable = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rem", 32'(remaining_ms), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);

    // 1: 3 ms with irq enabled
    run_and_check(16'd3, 1'b1, 1'b0);

    // 2: zero-length run expires on the arming edge
    start = 1'b0;
    @(negedge clk);
    check("ack_done", 32'(done), 32'd0);
    time_ms = 16'd0;
    interrupt_enable = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_irq", 32'(irq), 32'd1);
    check("zero_rem", 32'(remaining_ms), 32'd0);
    @(negedge clk);
    check("zero_hold", 32'(done), 32'd1);
    check("zero_irq_once", 32'(irq), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("zero_ack", 32'(done), 32'd0);

    // 3: abort after 5 clocks, then a full re-run
    time_ms = 16'd3;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
      check("abort_irq", 32'(irq), 32'd0);
    end
    check("abort_rem_mid", 32'(remaining_ms), 32'd2);
    start = 1'b0;
    @(negedge clk);
    check("abort_rem", 32'(remaining_ms), 32'd0);
    check("abort_done2", 32'(done), 32'd0);
    check("abort_irq2", 32'(irq), 32'd0);
    run_and_check(16'd3, 1'b1, 1'b0);

    // 4: irq disabled, time_ms changed mid-run
    start = 1'b0;
    @(negedge clk);
    run_and_check(16'd2, 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // 5: asynchronous reset mid-run, then fresh arming with start still high
    time_ms = 16'd5;
    interrupt_enable = 1'b1;
    start = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_rem", 32'(remaining_ms), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_done", 32'(done), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_rem", 32'(remaining_ms), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check(16'd2, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // 6: TICK_DIV=1, full 16-bit count
    b_time_ms = 16'hFFFF;
    b_interrupt_enable = 1'b1;
    b_start = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      @(negedge clk);
      if (b_irq) b_irq_count = b_irq_count + 1;
      if (k == 0) check("big_rem0", 32'(b_remaining_ms), 32'h0000FFFF);
      if (k == 1) check("big_rem1", 32'(b_remaining_ms), 32'h0000FFFE);
      if (k == 32768) check("big_rem_mid", 32'(b_remaining_ms), 32'd32767);
      if (k == 65534) begin
        check("big_done_early", 32'(b_done), 32'd0);
        check("big_rem_last", 32'(b_remaining_ms), 32'd1);
      end
      if (k == 65535) begin
        check("big_done", 32'(b_done), 32'd1);
        check("big_irq", 32'(b_irq), 32'd1);
        check("big_rem_end", 32'(b_remaining_ms), 32'd0);
      end
      if (k == 65536) begin
        check("big_hold", 32'(b_done), 32'd1);
        check("big_rem_nowrap", 32'(b_remaining_ms), 32'd0);
      end
    end
    check("big_irq_count", 32'(b_irq_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
